// File: rtl/dram_id_remap_pkg.sv
// Shared types and helpers for the DRAM AXI ID remapper.
package dram_id_remap_pkg;

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] full_stall;
        logic [31:0] peak;
    } stats_t;

    // Width of a slot index; a single-slot table still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_id_remap_table.sv
// One direction of the ID remapper: slot allocation, ID table, response lookup/free.
// Optional stats under DRAM_ID_REMAP_STATS_EN.
module dram_id_remap_table
    import dram_id_remap_pkg::*;
#(
    parameter int NumSlots   = 16,
    parameter int SlvIdWidth = 6,
    parameter int MstIdWidth = 4,
    parameter bit UseLast    = 1'b1,
    localparam int CntW      = $clog2(NumSlots + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SlvIdWidth-1:0] ax_id_i,
    input  logic                  ax_valid_i,
    output logic                  ax_ready_o,
    output logic [MstIdWidth-1:0] mst_ax_id_o,
    output logic                  mst_ax_valid_o,
    input  logic                  mst_ax_ready_i,
    input  logic [MstIdWidth-1:0] rsp_id_i,
    input  logic                  rsp_last_i,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    output logic [SlvIdWidth-1:0] slv_rsp_id_o,
    output logic                  slv_rsp_valid_o,
    input  logic                  slv_rsp_ready_i,
    output logic [CntW-1:0]       outstanding_o,
`ifdef DRAM_ID_REMAP_STATS_EN
    output logic [31:0]           full_stall_o,
    output logic [31:0]           peak_o,
`endif
    output logic                  err_o
);

    localparam int IdxW = idx_width(NumSlots);
    localparam logic [MstIdWidth:0] SlotLim = (MstIdWidth + 1)'(NumSlots);

    logic [NumSlots-1:0]                 r_busy;
    logic [NumSlots-1:0][SlvIdWidth-1:0] r_table;
    logic                                r_err;

    logic            w_any_free;
    logic [IdxW-1:0] w_free_idx;
    logic            w_alloc;
    logic            w_in_range;
    logic [IdxW-1:0] w_rsp_idx;
    logic            w_hit;
    logic            w_fire;
    logic            w_free;
    logic [NumSlots-1:0] w_set;
    logic [NumSlots-1:0] w_clr;
    logic [CntW-1:0] w_cnt;

    // Descending scan so the last assignment wins with the lowest free index.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IdxW'(i);
            end
        end
    end

    assign w_alloc        = ax_valid_i && mst_ax_ready_i && w_any_free;
    assign ax_ready_o     = mst_ax_ready_i && w_any_free;
    assign mst_ax_valid_o = ax_valid_i && w_any_free;

    always_comb begin
        mst_ax_id_o = '0;
        mst_ax_id_o[IdxW-1:0] = w_free_idx;
    end

    assign w_in_range      = {1'b0, rsp_id_i} < SlotLim;
    assign w_rsp_idx       = rsp_id_i[IdxW-1:0];
    assign w_hit           = w_in_range && r_busy[w_rsp_idx];
    assign slv_rsp_id_o    = w_in_range ? r_table[w_rsp_idx] : '0;
    assign slv_rsp_valid_o = rsp_valid_i;
    assign rsp_ready_o     = slv_rsp_ready_i;
    assign w_fire          = rsp_valid_i && slv_rsp_ready_i;
    assign w_free          = w_fire && w_hit && (UseLast ? rsp_last_i : 1'b1);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_alloc) w_set[w_free_idx] = 1'b1;
        if (w_free)  w_clr[w_rsp_idx]  = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy  <= '0;
            r_table <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
            if (w_alloc) r_table[w_free_idx] <= ax_id_i;
            if (w_fire && !w_hit) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NumSlots; i++) w_cnt = w_cnt + CntW'(r_busy[i]);
    end

    assign outstanding_o = w_cnt;
    assign err_o         = r_err;

`ifdef DRAM_ID_REMAP_STATS_EN
    stats_t r_stats;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stats <= '0;
        end else begin
            if (ax_valid_i && !w_any_free && r_stats.full_stall != SAT_MAX)
                r_stats.full_stall <= r_stats.full_stall + 32'd1;
            if (32'(w_cnt) > r_stats.peak)
                r_stats.peak <= 32'(w_cnt);
        end
    end

    assign full_stall_o = r_stats.full_stall;
    assign peak_o       = r_stats.peak;
`endif

endmodule

// File: rtl/dram_id_remap.sv
// Wide-to-narrow AXI ID remapper for the DRAM controller port, read and write tables.
// Define DRAM_ID_REMAP_STATS_EN to add full-stall and peak-outstanding counters.
module dram_id_remap
    import dram_id_remap_pkg::*;
#(
    parameter int SlvIdWidth = 6,
    parameter int MstIdWidth = 4,
    parameter int NumRdSlots = 16,
    parameter int NumWrSlots = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [SlvIdWidth-1:0]           slv_ar_id_i,
    input  logic                            slv_ar_valid_i,
    output logic                            slv_ar_ready_o,
    output logic [MstIdWidth-1:0]           mst_ar_id_o,
    output logic                            mst_ar_valid_o,
    input  logic                            mst_ar_ready_i,
    input  logic [MstIdWidth-1:0]           mst_r_id_i,
    input  logic                            mst_r_last_i,
    input  logic                            mst_r_valid_i,
    output logic                            mst_r_ready_o,
    output logic [SlvIdWidth-1:0]           slv_r_id_o,
    output logic                            slv_r_valid_o,
    input  logic                            slv_r_ready_i,
    input  logic [SlvIdWidth-1:0]           slv_aw_id_i,
    input  logic                            slv_aw_valid_i,
    output logic                            slv_aw_ready_o,
    output logic [MstIdWidth-1:0]           mst_aw_id_o,
    output logic                            mst_aw_valid_o,
    input  logic                            mst_aw_ready_i,
    input  logic [MstIdWidth-1:0]           mst_b_id_i,
    input  logic                            mst_b_valid_i,
    output logic                            mst_b_ready_o,
    output logic [SlvIdWidth-1:0]           slv_b_id_o,
    output logic                            slv_b_valid_o,
    input  logic                            slv_b_ready_i,
    output logic [$clog2(NumRdSlots+1)-1:0] rd_outstanding_o,
    output logic [$clog2(NumWrSlots+1)-1:0] wr_outstanding_o,
`ifdef DRAM_ID_REMAP_STATS_EN
    output logic [31:0]                     rd_full_stall_o,
    output logic [31:0]                     wr_full_stall_o,
    output logic [31:0]                     rd_peak_o,
    output logic [31:0]                     wr_peak_o,
`endif
    output logic                            err_o
);

    logic w_rd_err;
    logic w_wr_err;

    dram_id_remap_table #(
        .NumSlots(NumRdSlots), .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .UseLast(1'b1)
    ) u_rd (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ax_id_i         (slv_ar_id_i),
        .ax_valid_i      (slv_ar_valid_i),
        .ax_ready_o      (slv_ar_ready_o),
        .mst_ax_id_o     (mst_ar_id_o),
        .mst_ax_valid_o  (mst_ar_valid_o),
        .mst_ax_ready_i  (mst_ar_ready_i),
        .rsp_id_i        (mst_r_id_i),
        .rsp_last_i      (mst_r_last_i),
        .rsp_valid_i     (mst_r_valid_i),
        .rsp_ready_o     (mst_r_ready_o),
        .slv_rsp_id_o    (slv_r_id_o),
        .slv_rsp_valid_o (slv_r_valid_o),
        .slv_rsp_ready_i (slv_r_ready_i),
        .outstanding_o   (rd_outstanding_o),
`ifdef DRAM_ID_REMAP_STATS_EN
        .full_stall_o    (rd_full_stall_o),
        .peak_o          (rd_peak_o),
`endif
        .err_o           (w_rd_err)
    );

    // Every B response is a complete transaction, so last is tied high.
    dram_id_remap_table #(
        .NumSlots(NumWrSlots), .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .UseLast(1'b0)
    ) u_wr (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ax_id_i         (slv_aw_id_i),
        .ax_valid_i      (slv_aw_valid_i),
        .ax_ready_o      (slv_aw_ready_o),
        .mst_ax_id_o     (mst_aw_id_o),
        .mst_ax_valid_o  (mst_aw_valid_o),
        .mst_ax_ready_i  (mst_aw_ready_i),
        .rsp_id_i        (mst_b_id_i),
        .rsp_last_i      (1'b1),
        .rsp_valid_i     (mst_b_valid_i),
        .rsp_ready_o     (mst_b_ready_o),
        .slv_rsp_id_o    (slv_b_id_o),
        .slv_rsp_valid_o (slv_b_valid_o),
        .slv_rsp_ready_i (slv_b_ready_i),
        .outstanding_o   (wr_outstanding_o),
`ifdef DRAM_ID_REMAP_STATS_EN
        .full_stall_o    (wr_full_stall_o),
        .peak_o          (wr_peak_o),
`endif
        .err_o           (w_wr_err)
    );

    assign err_o = w_rd_err | w_wr_err;

endmodule

// File: tb/tb_dram_id_remap.sv
// Directed test-plan scenarios plus random traffic against a slot-table reference model.
module tb_dram_id_remap;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] ar_id, aw_id, slv_r_id, slv_b_id;
    logic [3:0] r_id, b_id, mst_ar_id, mst_aw_id;
    logic ar_v, ar_rdy, r_v, r_last, r_rdy, aw_v, aw_rdy, b_v, b_rdy;
    logic slv_ar_ready, mst_ar_valid, mst_r_ready, slv_r_valid;
    logic slv_aw_ready, mst_aw_valid, mst_b_ready, slv_b_valid;
    logic [4:0] rd_out, wr_out;
    logic err;
`ifdef DRAM_ID_REMAP_STATS_EN
    logic [31:0] rd_stall, wr_stall, rd_peak, wr_peak;
`endif

    dram_id_remap dut (
        .clk_i(clk), .rst_i(rst),
        .slv_ar_id_i(ar_id), .slv_ar_valid_i(ar_v), .slv_ar_ready_o(slv_ar_ready),
        .mst_ar_id_o(mst_ar_id), .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(ar_rdy),
        .mst_r_id_i(r_id), .mst_r_last_i(r_last), .mst_r_valid_i(r_v), .mst_r_ready_o(mst_r_ready),
        .slv_r_id_o(slv_r_id), .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(r_rdy),
        .slv_aw_id_i(aw_id), .slv_aw_valid_i(aw_v), .slv_aw_ready_o(slv_aw_ready),
        .mst_aw_id_o(mst_aw_id), .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(aw_rdy),
        .mst_b_id_i(b_id), .mst_b_valid_i(b_v), .mst_b_ready_o(mst_b_ready),
        .slv_b_id_o(slv_b_id), .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(b_rdy),
        .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out),
`ifdef DRAM_ID_REMAP_STATS_EN
        .rd_full_stall_o(rd_stall), .wr_full_stall_o(wr_stall),
        .rd_peak_o(rd_peak), .wr_peak_o(wr_peak),
`endif
        .err_o(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: busy sets and remembered SoC IDs per direction.
    logic [15:0] rb, wb;
    logic [5:0]  rt [16];
    logic [5:0]  wt [16];
    bit          merr;
    int          rstall, wstall, rpeak, wpeak;

    function automatic int lowfree(input logic [15:0] b);
        for (int i = 0; i < 16; i++) if (!b[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        rb = '0; wb = '0; merr = 0;
        rstall = 0; wstall = 0; rpeak = 0; wpeak = 0;
        for (int i = 0; i < 16; i++) begin rt[i] = '0; wt[i] = '0; end
    endtask

    task automatic idle();
        ar_v = 0; aw_v = 0; r_v = 0; b_v = 0; r_last = 0;
        ar_rdy = 1; aw_rdy = 1; r_rdy = 1; b_rdy = 1;
        ar_id = '0; aw_id = '0; r_id = '0; b_id = '0;
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cyc();
        int rf, wf;
        logic [15:0] nrb, nwb;
        #1;
        rf = lowfree(rb);
        wf = lowfree(wb);
        chk("mst_ar_valid", 32'(mst_ar_valid), 32'(ar_v && rf >= 0));
        chk("slv_ar_ready", 32'(slv_ar_ready), 32'(ar_rdy && rf >= 0));
        if (rf >= 0) chk("mst_ar_id", 32'(mst_ar_id), 32'(rf));
        chk("mst_aw_valid", 32'(mst_aw_valid), 32'(aw_v && wf >= 0));
        chk("slv_aw_ready", 32'(slv_aw_ready), 32'(aw_rdy && wf >= 0));
        if (wf >= 0) chk("mst_aw_id", 32'(mst_aw_id), 32'(wf));
        chk("slv_r_id", 32'(slv_r_id), 32'(rt[r_id]));
        chk("slv_r_valid", 32'(slv_r_valid), 32'(r_v));
        chk("mst_r_ready", 32'(mst_r_ready), 32'(r_rdy));
        chk("slv_b_id", 32'(slv_b_id), 32'(wt[b_id]));
        chk("slv_b_valid", 32'(slv_b_valid), 32'(b_v));
        chk("mst_b_ready", 32'(mst_b_ready), 32'(b_rdy));
        chk("rd_outstanding", 32'(rd_out), 32'($countones(rb)));
        chk("wr_outstanding", 32'(wr_out), 32'($countones(wb)));
        chk("err", 32'(err), 32'(merr));
`ifdef DRAM_ID_REMAP_STATS_EN
        chk("rd_stall", rd_stall, 32'(rstall));
        chk("wr_stall", wr_stall, 32'(wstall));
        chk("rd_peak", rd_peak, 32'(rpeak));
        chk("wr_peak", wr_peak, 32'(wpeak));
`endif
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            nrb = rb;
            nwb = wb;
            if (r_v && r_rdy && !rb[r_id]) merr = 1;
            if (b_v && b_rdy && !wb[b_id]) merr = 1;
            if (r_v && r_rdy && r_last && rb[r_id]) nrb[r_id] = 1'b0;
            if (b_v && b_rdy && wb[b_id]) nwb[b_id] = 1'b0;
            if (ar_v && ar_rdy && rf >= 0) begin nrb[rf] = 1'b1; rt[rf] = ar_id; end
            if (aw_v && aw_rdy && wf >= 0) begin nwb[wf] = 1'b1; wt[wf] = aw_id; end
            if (ar_v && rf < 0) rstall++;
            if (aw_v && wf < 0) wstall++;
            if ($countones(rb) > rpeak) rpeak = $countones(rb);
            if ($countones(wb) > wpeak) wpeak = $countones(wb);
            rb = nrb;
            wb = nwb;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] ooo_ids [3];
        logic [3:0] ooo_ret [3];
        ooo_ids = '{6'h05, 6'h11, 6'h3F};
        ooo_ret = '{4'd2, 4'd0, 4'd1};
        idle();
        model_clear();
        repeat (3) @(negedge clk);
        rst = 0;
        cyc();

        // Single read, four beats.
        ar_v = 1; ar_id = 6'h2A;
        #1 chk("single_mst_id", 32'(mst_ar_id), 32'd0);
        cyc();
        ar_v = 0;
        #1 chk("single_cnt_busy", 32'(rd_out), 32'd1);
        r_v = 1; r_id = 4'd0;
        for (int b = 0; b < 4; b++) begin
            r_last = (b == 3);
            #1 chk("single_r_id", 32'(slv_r_id), 32'h2A);
            cyc();
        end
        idle();
        #1 chk("single_cnt_end", 32'(rd_out), 32'd0);

        // Out-of-order return.
        for (int i = 0; i < 3; i++) begin
            ar_v = 1; ar_id = ooo_ids[i];
            cyc();
        end
        idle();
        r_v = 1; r_last = 1;
        for (int i = 0; i < 3; i++) begin
            r_id = ooo_ret[i];
            #1 chk("ooo_r_id", 32'(slv_r_id), 32'(ooo_ids[ooo_ret[i]]));
            cyc();
        end
        idle();
        #1 chk("ooo_cnt_end", 32'(rd_out), 32'd0);

        // Fill all read slots, then free slot 5 while the 17th request waits.
        for (int i = 0; i < 16; i++) begin
            ar_v = 1; ar_id = 6'(i + 8);
            cyc();
        end
        ar_id = 6'h33;
        #1 chk("full_ar_ready", 32'(slv_ar_ready), 32'd0);
        chk("full_ar_valid", 32'(mst_ar_valid), 32'd0);
        r_v = 1; r_last = 1; r_id = 4'd5;
        cyc();
        r_v = 0;
        #1 chk("full_realloc_id", 32'(mst_ar_id), 32'd5);
        chk("full_realloc_rdy", 32'(slv_ar_ready), 32'd1);
        cyc();
        ar_v = 0;
        r_v = 1; r_id = 4'd5;
        #1 chk("full_realloc_tab", 32'(slv_r_id), 32'h33);
        for (int i = 0; i < 16; i++) begin
            r_id = 4'(i);
            cyc();
        end
        idle();

        // Spurious B on a free write slot.
        b_v = 1; b_id = 4'd3;
        #1 chk("spur_b_valid", 32'(slv_b_valid), 32'd1);
        cyc();
        b_v = 0;
        #1 chk("spur_err", 32'(err), 32'd1);
        chk("spur_wr_cnt", 32'(wr_out), 32'd0);
        cyc();
        cyc();

        // Reset with four reads outstanding.
        for (int i = 0; i < 4; i++) begin
            ar_v = 1; ar_id = 6'(i);
            cyc();
        end
        ar_v = 0;
        rst = 1;
        cyc();
        rst = 0;
        #1 chk("rst_rd_cnt", 32'(rd_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
`ifdef DRAM_ID_REMAP_STATS_EN
        chk("rst_rd_peak", rd_peak, 32'd0);
        chk("rst_rd_stall", rd_stall, 32'd0);
`endif
        cyc();

        // Random traffic on both directions.
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 399) == 0);
            ar_v   = ($urandom_range(0, 2) != 0);
            aw_v   = ($urandom_range(0, 2) != 0);
            ar_id  = 6'($urandom);
            aw_id  = 6'($urandom);
            ar_rdy = ($urandom_range(0, 3) != 0);
            aw_rdy = ($urandom_range(0, 3) != 0);
            r_rdy  = ($urandom_range(0, 3) != 0);
            b_rdy  = ($urandom_range(0, 3) != 0);
            r_last = ($urandom_range(0, 2) == 0);
            r_v = 0;
            b_v = 0;
            if ($urandom_range(0, 63) == 0) begin
                r_v = 1; r_id = 4'($urandom);
            end else if (rb != 0 && $urandom_range(0, 1) == 1) begin
                r_v = 1;
                do r_id = 4'($urandom); while (!rb[r_id]);
            end
            if ($urandom_range(0, 63) == 0) begin
                b_v = 1; b_id = 4'($urandom);
            end else if (wb != 0 && $urandom_range(0, 2) == 0) begin
                b_v = 1;
                do b_id = 4'($urandom); while (!wb[b_id]);
            end
            cyc();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_id_remap.md
Name: dram_id_remap

Overview:
- Replaces the single-register ID downsizer in front of the DRAM controller AXI port.
- Remaps wide SoC AXI IDs onto a narrow controller ID space using per-direction slot tables. Supports many outstanding transactions and out-of-order responses.
- Sits after the DRAM-side spill register, in the controller clock domain.
- Handles only ID and valid/ready. All other AXI payload bypasses the block alongside it.

Parameters:
- SlvIdWidth, 6, SoC-side AXI ID width.
- MstIdWidth, 4, controller-side AXI ID width.
- NumRdSlots, 16, maximum outstanding reads; must be ≤ 2**MstIdWidth.
- NumWrSlots, 16, maximum outstanding writes; must be ≤ 2**MstIdWidth.

Ports:
- clk_i  in  1  controller AXI clock.
- rst_i  in  1  synchronous, active-high reset.
- slv_ar_id_i / slv_ar_valid_i / slv_ar_ready_o  in/in/out  SlvIdWidth/1/1  SoC AR ID and handshake.
- mst_ar_id_o / mst_ar_valid_o / mst_ar_ready_i  out/out/in  MstIdWidth/1/1  controller AR ID and handshake.
- mst_r_id_i / mst_r_last_i / mst_r_valid_i / mst_r_ready_o  in/in/in/out  MstIdWidth/1/1/1  controller R channel.
- slv_r_id_o / slv_r_valid_o / slv_r_ready_i  out/out/in  SlvIdWidth/1/1  SoC R channel.
- AW and B ports: same set as AR and R, prefixed slv_aw_/mst_aw_ and mst_b_/slv_b_; the B channel has no last.
- rd_outstanding_o  out  $clog2(NumRdSlots+1)  busy read slots.
- wr_outstanding_o  out  $clog2(NumWrSlots+1)  busy write slots.
- err_o  out  1  sticky: response arrived on a free slot.

Behaviour:
- Each direction has a busy vector and an ID table (NumSlots × SlvIdWidth).
- Allocation:
  - Free slot = lowest-index non-busy slot.
  - mst_ax_valid_o = slv_ax_valid_i && any_free.
  - slv_ax_ready_o = mst_ax_ready_i && any_free.
  - mst_ax_id_o = free slot index, zero-extended.
- On mst handshake, the table entry is written with slv_ax_id_i and the busy bit is set at the next edge. Allocation latency is 0 cycles; the slot is busy from the following cycle.
- Response path is combinational:
  - slv_x_id_o = table[mst_x_id_i].
  - slv_x_valid_o = mst_x_valid_i.
  - mst_x_ready_o = slv_x_ready_i.
- Free:
  - R: on valid && ready && last, the busy bit clears at the next edge. R beats without last do not free.
  - B: on valid && ready, the busy bit clears at the next edge.
- Full: with no free slot, the AX ready and valid outputs are 0 and the request is held. No ordering is imposed on other channels.
- Simultaneous allocate and free in one cycle: both take effect. The freed slot is not visible for allocation until the next cycle. The same slot can never be allocated and freed together.
- Response with a mst ID whose slot is not busy:
  - The response is still forwarded, with slv ID taken from the stale table entry.
  - err_o is set and held until reset.
  - The busy vector is unchanged.
- A mst ID ≥ NumSlots is treated the same as a free slot (err_o set).
- Outstanding counts equal popcount(busy).
- Reset, including mid-operation:
  - Busy vectors, tables and err_o are cleared; outstanding counts = 0.
  - Ready/valid outputs reflect the cleared state combinationally.
  - In-flight controller responses received after reset assert err_o. The controller reset is required to coincide.
- Read and write directions are fully independent.

Optional Feature:
- Macro DRAM_ID_REMAP_STATS_EN.
- Defined:
  - Adds outputs rd_full_stall_o and wr_full_stall_o, 32-bit each. Each counts cycles where ax_valid is high and no slot is free.
  - Adds rd_peak_o and wr_peak_o, the maximum outstanding count seen.
  - Counters saturate at all-ones and clear on rst_i.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package dram_id_remap_pkg: slot-index width function, a stats struct typedef, and the saturating-increment constant.
- Sub-module dram_id_remap_table, instantiated once per direction. Parameters: NumSlots, SlvIdWidth, MstIdWidth, UseLast. It holds the busy vector, ID table, lowest-free encoder, popcount, error detect and optional stats.
- The top level only wires AR/R and AW/B through the two instances and ORs the two error flags into err_o.

Test Plan:
- Single read: AR ID 0x2A → mst ID 0. Controller returns R ID 0, four beats with last on beat 4 → slv ID 0x2A on all beats; rd_outstanding goes 1 → 0 after beat 4.
- Out of order: AR IDs 0x05, 0x11, 0x3F → mst IDs 0, 1, 2. R returned for 2, 0, 1 → slv IDs 0x3F, 0x05, 0x11; count ends at 0.
- Full: 16 ARs accepted with controller ready held high. 17th AR → slv_ar_ready_o = 0 and mst_ar_valid_o = 0. Free slot 5 via B... R last → 17th issues with mst ID 5 one cycle later.
- Same-cycle free and allocate with the table full → the new AR stalls that cycle and is accepted the next cycle with the freed index.
- Spurious B on mst ID 3 while slot 3 is free → B is forwarded, err_o = 1 and stays 1; wr_outstanding is unchanged.
- Reset asserted with 4 reads outstanding → outstanding = 0 and err_o = 0 next cycle. With DRAM_ID_REMAP_STATS_EN, stall and peak counters read 0.
